// File: rtl/ysyx_23060187_alu_mc.sv
// Handshaked multi-cycle EX-stage ALU: logic/shift/add/compare ops finish in one cycle,
// unsigned multiply/divide/remainder iterate one bit per cycle.
module ysyx_23060187_alu_mc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_ctrl,
    input  logic [W-1:0] opnum1,
    input  logic [W-1:0] opnum2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         cout
);
    localparam int SHW = $clog2(W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q;
    logic [SHW-1:0] cnt_q;
    logic           fin_q;
    logic           dz_q;
    logic [3:0]     op_q;
    logic [2*W-1:0] prod_q;
    logic [W-1:0]   opnd_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   result_q;
    logic           zero_q;
    logic           cout_q;

    logic [W:0]     add_s;
    logic [W:0]     sub_s;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   fast_res;
    logic           fast_cout;
    logic           is_mc;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_sh;
    logic [W:0]     div_diff;
    logic [W-1:0]   mc_res;

    assign add_s = {1'b0, opnum1} + {1'b0, opnum2};
    assign sub_s = {1'b0, opnum1} + {1'b0, ~opnum2} + {{W{1'b0}}, 1'b1};
    assign shamt = opnum2[SHW-1:0];
    assign is_mc = (alu_ctrl >= 4'd10) && (alu_ctrl <= 4'd13);

    always_comb begin
        fast_res  = '0;
        fast_cout = 1'b0;
        case (alu_ctrl)
            4'd0: fast_res = opnum1 & opnum2;
            4'd1: fast_res = opnum1 | opnum2;
            4'd2: begin fast_res = add_s[W-1:0]; fast_cout = add_s[W]; end
            4'd3: fast_res = opnum1 << shamt;
            4'd4: fast_res = opnum1 >> shamt;
            4'd5: fast_res = opnum1 ^ opnum2;
            4'd6: begin fast_res = sub_s[W-1:0]; fast_cout = sub_s[W]; end
            4'd7: fast_res = $signed(opnum1) >>> shamt;
            4'd8: fast_res = {{(W-1){1'b0}}, $signed(opnum1) < $signed(opnum2)};
            4'd9: fast_res = {{(W-1){1'b0}}, opnum1 < opnum2};
            default: fast_res = '0;
        endcase
    end

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, prod_q[W-1:1]};

    // Restoring division: trial-subtract the divisor from the shifted partial remainder.
    assign div_sh   = {rem_q, quo_q[W-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};

    always_comb begin
        case (op_q)
            4'd10:   mc_res = prod_q[W-1:0];
            4'd11:   mc_res = prod_q[2*W-1:W];
            4'd12:   mc_res = quo_q;
            default: mc_res = rem_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
            dz_q     <= 1'b0;
            op_q     <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            fin_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= alu_ctrl;
                        if (is_mc) begin
                            state_q <= BUSY;
                            fin_q   <= 1'b0;
                            opnd_q  <= opnum2;
                            prod_q  <= {{W{1'b0}}, opnum1};
                            if (alu_ctrl[2] && (opnum2 == '0)) begin
                                dz_q  <= 1'b1;
                                cnt_q <= '0;
                                quo_q <= '1;
                                rem_q <= opnum1;
                            end else begin
                                dz_q  <= 1'b0;
                                cnt_q <= SHW'(W - 1);
                                quo_q <= opnum1;
                                rem_q <= '0;
                            end
                        end else begin
                            state_q  <= DONE;
                            result_q <= fast_res;
                            zero_q   <= (fast_res == '0);
                            cout_q   <= fast_cout;
                        end
                    end
                end
                BUSY: begin
                    if (fin_q) begin
                        state_q  <= DONE;
                        fin_q    <= 1'b0;
                        result_q <= mc_res;
                        zero_q   <= (mc_res == '0);
                        cout_q   <= 1'b0;
                    end else begin
                        if (!dz_q) begin
                            if (op_q[2]) begin
                                if (!div_diff[W]) begin
                                    rem_q <= div_diff[W-1:0];
                                    quo_q <= {quo_q[W-2:0], 1'b1};
                                end else begin
                                    rem_q <= div_sh[W-1:0];
                                    quo_q <= {quo_q[W-2:0], 1'b0};
                                end
                            end else begin
                                prod_q <= mul_next;
                            end
                        end
                        if (cnt_q == '0) fin_q <= 1'b1;
                        else             cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_ysyx_23060187_alu_mc.sv
// Directed bench for the multi-cycle ALU: single-cycle ops, iterative mul/div,
// backpressure, flush and asynchronous reset aborts.
module tb_ysyx_23060187_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   alu_ctrl = '0;
    logic [W-1:0] opnum1 = '0;
    logic [W-1:0] opnum2 = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;

    int total = 0;
    int bad   = 0;

    ysyx_23060187_alu_mc #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
        .opnum1(opnum1), .opnum2(opnum2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .cout(cout)
    );

    always #5 clk = ~clk;

    // Present an op for one edge, then scramble the inputs since they are don't-care after accept.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_ctrl = op; opnum1 = a; opnum2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom); opnum1 = $urandom; opnum2 = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (result !== '0) begin bad++; $display("FAIL rst_result: got %h want 0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero: got %b want 1", zero); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL rst_cout: got %b want 0", cout); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_hs: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
        total++; if (result !== '0 || zero !== 1'b1 || cout !== 1'b0) begin bad++; $display("FAIL rst_release_out: got %h %b %b want 0 1 0", result, zero, cout); end
        $display("reset: in_ready=%b out_valid=%b result=%h zero=%b cout=%b", in_ready, out_valid, result, zero, cout);
    endtask

    task automatic test_add_sub();
        logic [3:0]   ops [4];
        logic [W-1:0] as  [4];
        logic [W-1:0] bs  [4];
        logic [W-1:0] er  [4];
        logic         ez  [4];
        logic         ec  [4];
        int n;
        ops = '{4'd2, 4'd2, 4'd6, 4'd6};
        as  = '{32'hFFFF_FFFF, 32'd3, 32'd5, 32'd7};
        bs  = '{32'h1, 32'd4, 32'd7, 32'd5};
        er  = '{32'h0, 32'd7, 32'hFFFF_FFFE, 32'd2};
        ez  = '{1'b1, 1'b0, 1'b0, 1'b0};
        ec  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(n);
            $display("op=%0d a=%h b=%h edges=%0d result=%h zero=%b cout=%b", ops[i], as[i], bs[i], n, result, zero, cout);
            total++; if (n != 0) begin bad++; $display("FAIL addsub_latency[%0d]: got %0d want 0", i, n); end
            total++; if (result !== er[i]) begin bad++; $display("FAIL addsub_result[%0d]: got %h want %h", i, result, er[i]); end
            total++; if (zero !== ez[i] || cout !== ec[i]) begin bad++; $display("FAIL addsub_flags[%0d]: got z=%b c=%b want z=%b c=%b", i, zero, cout, ez[i], ec[i]); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL addsub_busy_ready[%0d]: got %b want 0", i, in_ready); end
            release_out();
        end
    endtask

    task automatic test_logic_shift_cmp();
        logic [3:0]   ops [10];
        logic [W-1:0] er  [10];
        logic [W-1:0] a;
        logic [W-1:0] b;
        int n;
        a = 32'hF0F0_1234;
        b = 32'h0FF0_0024;
        ops = '{4'd0, 4'd1, 4'd5, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd14, 4'd15};
        er  = '{32'h00F0_0024, 32'hFFF0_1234, 32'hFF00_1210, 32'h0F01_2340, 32'h0F0F_0123,
                32'hFF0F_0123, 32'h1, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], a, b);
            wait_done(n);
            $display("op=%0d a=%h b=%h edges=%0d result=%h zero=%b cout=%b", ops[i], a, b, n, result, zero, cout);
            total++; if (n != 0) begin bad++; $display("FAIL fast_latency[%0d]: got %0d want 0", i, n); end
            total++; if (result !== er[i]) begin bad++; $display("FAIL fast_result[op%0d]: got %h want %h", ops[i], result, er[i]); end
            total++; if (zero !== (er[i] == '0) || cout !== 1'b0) begin bad++; $display("FAIL fast_flags[op%0d]: got z=%b c=%b want z=%b c=0", ops[i], zero, cout, (er[i] == '0)); end
            release_out();
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]   ops [8];
        logic [W-1:0] as  [8];
        logic [W-1:0] bs  [8];
        logic [W-1:0] er  [8];
        int           el  [8];
        int n;
        ops = '{4'd10, 4'd11, 4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13};
        as  = '{32'h0001_0000, 32'h0001_0000, 32'd7, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd9, 32'd9};
        bs  = '{32'h0001_0000, 32'h0001_0000, 32'd6, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
        er  = '{32'h0, 32'h1, 32'd42, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
        el  = '{W + 1, W + 1, W + 1, W + 1, W + 1, W + 1, 2, 2};
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(n);
            $display("op=%0d a=%h b=%h edges=%0d result=%h zero=%b cout=%b", ops[i], as[i], bs[i], n, result, zero, cout);
            total++; if (n != el[i]) begin bad++; $display("FAIL muldiv_latency[%0d]: got %0d want %0d", i, n, el[i]); end
            total++; if (result !== er[i]) begin bad++; $display("FAIL muldiv_result[%0d]: got %h want %h", i, result, er[i]); end
            total++; if (zero !== (er[i] == '0) || cout !== 1'b0) begin bad++; $display("FAIL muldiv_flags[%0d]: got z=%b c=%b want z=%b c=0", i, zero, cout, (er[i] == '0)); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int n;
        issue(4'd2, 32'd1, 32'd2);
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd3 || zero !== 1'b0 || cout !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h z=%b c=%b want 1 0 3 0 0", i, out_valid, in_ready, result, zero, cout);
            end
            @(posedge clk); #1;
        end
        $display("backpressure: held result=%h", result);
        release_out();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_abort_reset();
        issue(4'd10, 32'd3, 32'd5);
        repeat (21) begin @(posedge clk); #1; end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL abort_rst_busy: got vld=%b rdy=%b want 0 0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        $display("abort reset: in_ready=%b out_valid=%b result=%h zero=%b", in_ready, out_valid, result, zero);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL abort_rst_hs: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
        total++; if (result !== '0 || zero !== 1'b1 || cout !== 1'b0) begin bad++; $display("FAIL abort_rst_out: got %h %b %b want 0 1 0", result, zero, cout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abort_flush();
        int n;
        int pulses;
        issue(4'd2, 32'd5, 32'd6);
        wait_done(n);
        total++; if (result !== 32'd11) begin bad++; $display("FAIL flush_pre: got %h want 0000000b", result); end
        release_out();
        issue(4'd10, 32'd3, 32'd3);
        repeat (21) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("abort flush: in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_hs: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
        total++; if (result !== 32'd11 || zero !== 1'b0 || cout !== 1'b0) begin bad++; $display("FAIL flush_hold: got %h %b %b want 0000000b 0 0", result, zero, cout); end
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL flush_no_pulse: got %0d want 0", pulses); end
        issue(4'd6, 32'd9, 32'd4);
        wait_done(n);
        $display("op=6 a=9 b=4 edges=%0d result=%h cout=%b", n, result, cout);
        total++; if (n != 0 || result !== 32'd5 || cout !== 1'b1) begin bad++; $display("FAIL flush_next_op: got n=%0d %h c=%b want 0 00000005 1", n, result, cout); end
        release_out();
    endtask

    task automatic test_flush_vs_valid();
        flush = 1'b1;
        alu_ctrl = 4'd2; opnum1 = 32'd1; opnum2 = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        $display("flush+valid: in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd5) begin
            bad++; $display("FAIL flush_wins: got rdy=%b vld=%b res=%h want 1 0 00000005", in_ready, out_valid, result);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'd12, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        $display("op=12 a=ffffffff b=10 edges=%0d result=%h", n, result);
        total++; if (result !== 32'h0FFF_FFFF) begin bad++; $display("FAIL b2b_divu: got %h want 0fffffff", result); end
        release_out();
        issue(4'd13, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        $display("op=13 a=ffffffff b=10 edges=%0d result=%h", n, result);
        total++; if (n != W + 1 || result !== 32'hF) begin bad++; $display("FAIL b2b_remu: got n=%0d %h want %0d 0000000f", n, result, W + 1); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic_shift_cmp();
        test_muldiv();
        test_backpressure();
        test_abort_reset();
        test_abort_flush();
        test_flush_vs_valid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
